// File: rtl/ddr_host_cmd_sequencer.sv
// DDR host command sequencer: power-up wait, fixed init command sequence, then one READA/WRITEA at a time.
// Optional ack watchdog: define ACK_TIMEOUT_EN (adds the TIMEOUT parameter and drives err).
module ddr_host_cmd_sequencer #(
  parameter int ASIZE     = 22,
  parameter int INIT_WAIT = 200
`ifdef ACK_TIMEOUT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  input  logic             req_write,
  input  logic [ASIZE-1:0] req_addr,
  output logic             req_ready,
  input  logic [12:0]      cfg_reg1,
  input  logic [15:0]      cfg_reg2,
  input  logic [ASIZE-1:0] cfg_mode,
  output logic [2:0]       cmd,
  output logic [ASIZE-1:0] addr,
  input  logic             cmd_ack,
  output logic             init_done,
  output logic             err,
  output logic [1:0]       state_dbg,
  output logic [2:0]       step_dbg
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready.
  // req_ready is registered and high only while idle; one command outstanding at a time.
  localparam logic [2:0] C_NOP   = 3'b000;
  localparam logic [2:0] C_READA = 3'b001;
  localparam logic [2:0] C_WRITA = 3'b010;
  localparam logic [2:0] C_REF   = 3'b011;
  localparam logic [2:0] C_PRE   = 3'b100;
  localparam logic [2:0] C_LMODE = 3'b101;
  localparam logic [2:0] C_LREG1 = 3'b110;
  localparam logic [2:0] C_LREG2 = 3'b111;
  localparam logic [15:0] WAIT_LAST = 16'(INIT_WAIT - 1);

  typedef enum logic [1:0] {PWR, ISSUE, GAP, IDLE} state_t;

  state_t      state;
  logic [2:0]  step;
  logic [15:0] pwr_cnt;
  logic [2:0]  next_step;
  logic [2:0]  load_cmd;
  logic [ASIZE-1:0] load_addr;
  logic        timeout_hit;

  assign state_dbg = state;
  assign step_dbg  = step;
  assign next_step = (state == PWR) ? 3'd0 : step + 3'd1;

  // Command and address for the init step about to be loaded into ISSUE.
  always_comb begin
    load_cmd  = C_NOP;
    load_addr = '0;
    case (next_step)
      3'd0: begin
        load_cmd  = C_LREG1;
        load_addr = {{(ASIZE-13){1'b0}}, cfg_reg1};
      end
      3'd1: begin
        load_cmd  = C_LREG2;
        load_addr = {{(ASIZE-16){1'b0}}, cfg_reg2};
      end
      3'd2:    load_cmd = C_PRE;
      3'd3:    load_cmd = C_REF;
      3'd4:    load_cmd = C_REF;
      3'd5: begin
        load_cmd  = C_LMODE;
        load_addr = cfg_mode;
      end
      default: load_cmd = C_NOP;
    endcase
  end

`ifdef ACK_TIMEOUT_EN
  logic [15:0] wd_cnt;

  // An ack on the timeout edge wins, so the watchdog only fires without one.
  assign timeout_hit = (state == ISSUE) && !cmd_ack && (wd_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if (state != ISSUE || cmd_ack) wd_cnt <= '0;
      else                           wd_cnt <= wd_cnt + 16'd1;
      if (timeout_hit) err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= PWR;
      step      <= 3'd0;
      pwr_cnt   <= '0;
      cmd       <= C_NOP;
      addr      <= '0;
      req_ready <= 1'b0;
      init_done <= 1'b0;
    end else begin
      case (state)
        PWR: begin
          if (pwr_cnt == WAIT_LAST) begin
            step  <= next_step;
            cmd   <= load_cmd;
            addr  <= load_addr;
            state <= ISSUE;
          end else begin
            pwr_cnt <= pwr_cnt + 16'd1;
          end
        end
        ISSUE: begin
          // Drop the command on the first ack; the decoder re-reads held LOAD_REG commands.
          if (cmd_ack || timeout_hit) begin
            cmd   <= C_NOP;
            addr  <= '0;
            state <= GAP;
          end
        end
        GAP: begin
          if (!init_done && step != 3'd5) begin
            step  <= next_step;
            cmd   <= load_cmd;
            addr  <= load_addr;
            state <= ISSUE;
          end else begin
            init_done <= 1'b1;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        IDLE: begin
          if (req_valid) begin
            cmd       <= req_write ? C_WRITA : C_READA;
            addr      <= req_addr;
            req_ready <= 1'b0;
            state     <= ISSUE;
          end
        end
        default: state <= PWR;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_host_cmd_sequencer.sv
// Bench for ddr_host_cmd_sequencer: controller ack model, per-cycle reference model, directed scenarios.
`timescale 1ns/1ps
module tb_ddr_host_cmd_sequencer;
  localparam int ASIZE     = 22;
  localparam int INIT_WAIT = 20;
`ifdef ACK_TIMEOUT_EN
  localparam int TIMEOUT   = 8;
`endif
  localparam logic [12:0]      CFG1 = 13'h0A5B;
  localparam logic [15:0]      CFG2 = 16'h0400;
  localparam logic [ASIZE-1:0] CFGM = 22'h000033;

  logic             clk;
  logic             reset_n;
  logic             req_valid;
  logic             req_write;
  logic [ASIZE-1:0] req_addr;
  logic             req_ready;
  logic [2:0]       cmd;
  logic [ASIZE-1:0] addr;
  logic             cmd_ack;
  logic             init_done;
  logic             err;
  logic [1:0]       state_dbg;
  logic [2:0]       step_dbg;

  ddr_host_cmd_sequencer #(
    .ASIZE(ASIZE),
    .INIT_WAIT(INIT_WAIT)
`ifdef ACK_TIMEOUT_EN
    , .TIMEOUT(TIMEOUT)
`endif
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_ready(req_ready),
    .cfg_reg1(CFG1), .cfg_reg2(CFG2), .cfg_mode(CFGM),
    .cmd(cmd), .addr(addr), .cmd_ack(cmd_ack),
    .init_done(init_done), .err(err), .state_dbg(state_dbg), .step_dbg(step_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- controller model (ack driver) ----------------
  logic       ack_en   = 1'b1;
  int         ack_lat  = 2;
  logic       stray    = 1'b0;
  logic [2:0] nack_cmd = 3'b000;

  initial begin
    int held;
    held    = 0;
    cmd_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (cmd != 3'b000) begin
        held++;
        cmd_ack = ack_en && (cmd != nack_cmd) && (held == ack_lat);
      end else begin
        held    = 0;
        cmd_ack = stray;
      end
    end
  end

  // ---------------- reference model + scoreboard ----------------
  logic [ASIZE+2:0] exp_q[$];
  logic [ASIZE+2:0] log_q[$];
  logic             model_on = 1'b0;
  logic [2:0]       p_cmd;
  logic [ASIZE-1:0] p_addr;
  logic             p_ready;
  logic             m_done, m_busy, m_err, gap_init, lm_pending, rel_pending;
  int               m_acks, m_held;

  task automatic model_reset();
    exp_q.delete();
    exp_q.push_back({3'b110, {(ASIZE-13){1'b0}}, CFG1});
    exp_q.push_back({3'b111, {(ASIZE-16){1'b0}}, CFG2});
    exp_q.push_back({3'b100, {ASIZE{1'b0}}});
    exp_q.push_back({3'b011, {ASIZE{1'b0}}});
    exp_q.push_back({3'b011, {ASIZE{1'b0}}});
    exp_q.push_back({3'b101, CFGM});
    p_cmd = 3'b000; p_addr = '0; p_ready = 1'b0;
    m_done = 1'b0; m_busy = 1'b0; m_err = 1'b0;
    gap_init = 1'b0; lm_pending = 1'b0; rel_pending = 1'b0;
    m_acks = 0; m_held = 0;
  endtask

  // Evaluated just after each rising edge: inputs still hold what that edge sampled.
  task automatic model_step();
    logic accepted, acked, timed;
    logic [ASIZE+2:0] e;
    accepted = p_ready && req_valid;
    acked    = (p_cmd != 3'b000) && cmd_ack;
    timed    = 1'b0;
`ifdef ACK_TIMEOUT_EN
    if (p_cmd != 3'b000 && !cmd_ack && m_held == TIMEOUT) begin
      timed = 1'b1;
      m_err = 1'b1;
    end
`endif
    if (lm_pending)  m_done = 1'b1;
    if (rel_pending) m_busy = 1'b0;
    lm_pending  = 1'b0;
    rel_pending = 1'b0;
    if (acked || timed) begin
      check("cmd_drop", cmd, 0);
      check("addr_drop", addr, 0);
      if (!m_done) begin
        m_acks++;
        gap_init   = (m_acks < 6);
        lm_pending = (m_acks == 6);
      end else begin
        rel_pending = 1'b1;
      end
      m_held = 0;
    end else if (p_cmd != 3'b000) begin
      check("cmd_hold", cmd, p_cmd);
      check("addr_hold", addr, p_addr);
      m_held++;
    end else begin
      if (accepted) begin
        exp_q.push_back({req_write ? 3'b010 : 3'b001, req_addr});
        m_busy = 1'b1;
      end
      if (accepted || gap_init) check("cmd_issued", cmd != 3'b000, 1);
      gap_init = 1'b0;
      if (cmd != 3'b000) begin
        if (exp_q.size() == 0) begin
          check("unexpected_cmd", cmd, 0);
        end else begin
          e = exp_q.pop_front();
          check("cmd_value", cmd, e[ASIZE+2:ASIZE]);
          check("addr_value", addr, e[ASIZE-1:0]);
        end
        log_q.push_back({cmd, addr});
        m_held = 1;
      end
    end
    check("req_ready", req_ready, m_done && !m_busy);
    check("init_done", init_done, m_done);
    check("err", err, m_err);
    p_cmd   = cmd;
    p_addr  = addr;
    p_ready = req_ready;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (model_on) model_step();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cmd(input logic [2:0] c, input string name);
    int n = 0;
    while (cmd != c && n < 500) begin @(negedge clk); n++; end
    check(name, cmd, c);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!init_done && n < 500) begin @(negedge clk); n++; end
    check("init_done_reached", init_done, 1);
  endtask

  task automatic pwr_wait_check();
    int n = 0;
    while (cmd != 3'b110 && n < 1000) begin @(posedge clk); #1; n++; end
    check("pwr_wait_window", (n >= INIT_WAIT - 1) && (n <= INIT_WAIT + 1), 1);
    @(negedge clk);
  endtask

  task automatic send(input logic wr, input logic [ASIZE-1:0] a, input logic keep);
    int n = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    check("req_wait_bound", n < 200, 1);
    @(negedge clk);
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic restart();
    model_on = 1'b0;
    reset_n  = 1'b0;
    #1;
    check("rst_cmd", cmd, 0);
    check("rst_addr", addr, 0);
    check("rst_init_done", init_done, 0);
    check("rst_req_ready", req_ready, 0);
    repeat (2) @(negedge clk);
    model_reset();
    log_q.delete();
    model_on = 1'b1;
    reset_n  = 1'b1;
    pwr_wait_check();
  endtask

  // ---------------- directed scenarios ----------------
  logic [ASIZE+2:0] init_exp [6];

  initial begin
    int n;
    init_exp[0] = {3'b110, 22'h000A5B};
    init_exp[1] = {3'b111, 22'h000400};
    init_exp[2] = {3'b100, 22'h000000};
    init_exp[3] = {3'b011, 22'h000000};
    init_exp[4] = {3'b011, 22'h000000};
    init_exp[5] = {3'b101, 22'h000033};
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    #12;
    check("reset_cmd", cmd, 0);
    check("reset_addr", addr, 0);
    check("reset_req_ready", req_ready, 0);
    check("reset_init_done", init_done, 0);
    check("reset_err", err, 0);
    check("reset_step", step_dbg, 0);
    model_reset();
    model_on = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;

    // Stray acks through the power-up wait and a request held during init.
    stray     = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 22'h3FFFFF;
    pwr_wait_check();
    stray = 1'b0;
    wait_cmd(3'b101, "reach_load_mode");
    req_valid = 1'b0;
    wait_done();
    check("init_cmd_count", log_q.size(), 6);
    for (int i = 0; i < 6; i++) check($sformatf("init_cmd_%0d", i), log_q[i], init_exp[i]);

    // Single write, then ready latency from accept.
    send(1'b1, 22'h012345, 1'b0);
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    check("ready_latency", n, 3);
    check("write_logged", log_q[6], {3'b010, 22'h012345});

    // Back-to-back read then write with valid held.
    send(1'b0, 22'h00ABCD, 1'b1);
    send(1'b1, 22'h2A0F0F, 1'b0);
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    check("b2b_count", log_q.size(), 9);
    check("b2b_read", log_q[7], {3'b001, 22'h00ABCD});
    check("b2b_write", log_q[8], {3'b010, 22'h2A0F0F});

    // Stray acks while idle must not issue anything.
    stray = 1'b1;
    repeat (5) @(negedge clk);
    stray = 1'b0;
    check("idle_no_cmd", log_q.size(), 9);

    // Reset while LOAD_REG2 waits for its ack.
    model_on = 1'b0;
    reset_n  = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    model_on = 1'b1;
    reset_n  = 1'b1;
    pwr_wait_check();
    wait_cmd(3'b111, "reach_load_reg2");
    restart();
    wait_done();
    check("restart_count", log_q.size(), 6);
    check("restart_first", log_q[0], init_exp[0]);

`ifdef ACK_TIMEOUT_EN
    // Controller never acks PRECHARGE: watchdog drops it after TIMEOUT cycles.
    nack_cmd = 3'b100;
    restart();
    wait_cmd(3'b100, "reach_precharge");
    n = 0;
    while (cmd == 3'b100 && n < 50) begin @(negedge clk); n++; end
    check("timeout_cycles", n, 8);
    check("timeout_err", err, 1);
    wait_done();
    check("err_sticky", err, 1);
    nack_cmd = 3'b000;
`endif

    repeat (3) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
